// File: rtl/tr_manual_mc.sv
// Multi-channel manual stepper controller. Each channel runs its own
// IDLE / MOVE / MOVE_N state machine and produces a square step train whose
// high and low phases last half_period clock cycles each. MOVE runs until
// stop; MOVE_N issues exactly the latched number of pulses and then strobes
// done for one cycle.
module tr_manual_mc #(
    parameter int WIDTH_MANUAL = 16,
    parameter int CHANNELS     = 2,
    parameter int DIV_WIDTH    = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [CHANNELS-1:0]                start,
    input  logic [CHANNELS-1:0]                start_N,
    input  logic [CHANNELS-1:0]                stop,
    input  logic [CHANNELS-1:0]                dir_in,
    input  logic [CHANNELS*2*WIDTH_MANUAL-1:0] PULSE_NUMBER,
    input  logic [DIV_WIDTH-1:0]               half_period,
    output logic [CHANNELS-1:0]                enable_MANUAL,
    output logic [CHANNELS-1:0]                step,
    output logic [CHANNELS-1:0]                dir,
    output logic [CHANNELS*2*WIDTH_MANUAL-1:0] count_N,
    output logic [CHANNELS-1:0]                done,
    output logic                               busy
);

    localparam int CW = 2 * WIDTH_MANUAL;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE   = 2'd1,
        MOVE_N = 2'd2
    } state_t;

    state_t               state_q  [CHANNELS];
    state_t               state_d  [CHANNELS];
    logic [CW-1:0]        count_q  [CHANNELS];
    logic [CW-1:0]        count_d  [CHANNELS];
    logic [CW-1:0]        target_q [CHANNELS];
    logic [CW-1:0]        target_d [CHANNELS];
    logic [CW-1:0]        target_in[CHANNELS];
    logic [DIV_WIDTH-1:0] div_q    [CHANNELS];
    logic [DIV_WIDTH-1:0] div_d    [CHANNELS];
    logic [CHANNELS-1:0]  en_q, en_d;
    logic [CHANNELS-1:0]  step_q, step_d;
    logic [CHANNELS-1:0]  dir_q, dir_d;
    logic [CHANNELS-1:0]  done_q, done_d;
    logic                 busy_q;
    logic [DIV_WIDTH-1:0] phase_reload;

    // Phase counter reload: a phase lasts reload+1 cycles, and 0 behaves like 1.
    always_comb begin
        phase_reload = (half_period == '0) ? '0 : half_period - DIV_WIDTH'(1);
    end

    // Per-channel target slicing and output mapping.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign target_in[g]            = PULSE_NUMBER[g*CW +: CW];
        assign count_N[g*CW +: CW]     = count_q[g];
    end

    assign enable_MANUAL = en_q;
    assign step          = step_q;
    assign dir           = dir_q;
    assign done          = done_q;
    assign busy          = busy_q;

    // Next-state and next-output logic for every channel; the first step edge
    // is produced on entry so the pulse train starts the cycle after request.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i]  = state_q[i];
            count_d[i]  = count_q[i];
            target_d[i] = target_q[i];
            div_d[i]    = div_q[i];
            en_d[i]     = en_q[i];
            step_d[i]   = step_q[i];
            dir_d[i]    = dir_q[i];
            done_d[i]   = 1'b0;
            case (state_q[i])
                IDLE: begin
                    step_d[i] = 1'b0;
                    en_d[i]   = 1'b0;
                    if (!stop[i] && (start[i] || start_N[i])) begin
                        state_d[i]  = start[i] ? MOVE : MOVE_N;
                        en_d[i]     = 1'b1;
                        dir_d[i]    = dir_in[i];
                        target_d[i] = target_in[i];
                        div_d[i]    = phase_reload;
                        if (!start[i] && target_in[i] == '0) begin
                            step_d[i]  = 1'b0;
                            count_d[i] = '0;
                            div_d[i]   = '0;
                        end else begin
                            step_d[i]  = 1'b1;
                            count_d[i] = CW'(1);
                        end
                    end
                end
                MOVE, MOVE_N: begin
                    if (stop[i]) begin
                        state_d[i] = IDLE;
                        en_d[i]    = 1'b0;
                        step_d[i]  = 1'b0;
                    end else if (div_q[i] != '0) begin
                        div_d[i] = div_q[i] - DIV_WIDTH'(1);
                    end else if (step_q[i]) begin
                        step_d[i] = 1'b0;
                        div_d[i]  = phase_reload;
                    end else if (state_q[i] == MOVE_N && count_q[i] == target_q[i]) begin
                        state_d[i] = IDLE;
                        en_d[i]    = 1'b0;
                        done_d[i]  = 1'b1;
                    end else begin
                        step_d[i] = 1'b1;
                        div_d[i]  = phase_reload;
                        if (count_q[i] != '1) begin
                            count_d[i] = count_q[i] + CW'(1);
                        end
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    en_d[i]    = 1'b0;
                    step_d[i]  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset wins over any move or request.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]  <= IDLE;
                count_q[i]  <= '0;
                target_q[i] <= '0;
                div_q[i]    <= '0;
            end
            en_q   <= '0;
            step_q <= '0;
            dir_q  <= '0;
            done_q <= '0;
            busy_q <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]  <= state_d[i];
                count_q[i]  <= count_d[i];
                target_q[i] <= target_d[i];
                div_q[i]    <= div_d[i];
            end
            en_q   <= en_d;
            step_q <= step_d;
            dir_q  <= dir_d;
            done_q <= done_d;
            busy_q <= |en_d;
        end
    end

endmodule

// File: tb/tb_tr_manual_mc.sv
// Scoreboard bench for tr_manual_mc: each issued move pushes its expected
// outcome (enable length, pulse count, done, direction) and a monitor checks
// it when the channel's enable drops.
module tb_tr_manual_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  start = '0;
    logic [1:0]  start_N = '0;
    logic [1:0]  stop = '0;
    logic [1:0]  dir_in = '0;
    logic [63:0] PULSE_NUMBER = '0;
    logic [15:0] half_period = 16'd1;
    logic [1:0]  enable_MANUAL;
    logic [1:0]  step;
    logic [1:0]  dir;
    logic [63:0] count_N;
    logic [1:0]  done;
    logic        busy;

    tr_manual_mc #(.WIDTH_MANUAL(16), .CHANNELS(2), .DIV_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .start_N(start_N), .stop(stop),
        .dir_in(dir_in), .PULSE_NUMBER(PULSE_NUMBER), .half_period(half_period),
        .enable_MANUAL(enable_MANUAL), .step(step), .dir(dir), .count_N(count_N),
        .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int pulses;
        bit done;
        bit dir;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int total = 0;
    int bad = 0;

    // Comparison helper shared by the stimulus and the monitor.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic pushExp(input int ch, input int len, input int pulses, input bit dn, input bit d);
        exp_t e;
        e.len = len; e.pulses = pulses; e.done = dn; e.dir = d;
        if (ch == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // Monitor: measures each move from enable rise to enable fall.
    int cyc = 0;
    int start_cyc[2];
    int pulses_seen[2];
    bit prev_en[2];
    bit prev_step[2];
    bit dir_seen[2];
    exp_t me;
    bit have;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            for (int ch = 0; ch < 2; ch++) begin
                prev_en[ch] = 1'b0;
                prev_step[ch] = 1'b0;
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (enable_MANUAL[ch] && !prev_en[ch]) begin
                    start_cyc[ch] = cyc;
                    pulses_seen[ch] = 0;
                    dir_seen[ch] = dir[ch];
                end
                if (step[ch] && !prev_step[ch]) pulses_seen[ch]++;
                if (!enable_MANUAL[ch] && prev_en[ch]) begin
                    have = 1'b0;
                    if (ch == 0 && q0.size() > 0) begin me = q0.pop_front(); have = 1'b1; end
                    if (ch == 1 && q1.size() > 0) begin me = q1.pop_front(); have = 1'b1; end
                    if (!have) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected_move_end ch=%0d actual=end required=none", ch);
                    end else begin
                        checkOutput($sformatf("ch%0d_enable_len", ch), 64'(cyc - start_cyc[ch]), 64'(me.len));
                        checkOutput($sformatf("ch%0d_pulses", ch), 64'(pulses_seen[ch]), 64'(me.pulses));
                        checkOutput($sformatf("ch%0d_count_N", ch), 64'(count_N[ch*32 +: 32]), 64'(me.pulses));
                        checkOutput($sformatf("ch%0d_done", ch), 64'(done[ch]), 64'(me.done));
                        checkOutput($sformatf("ch%0d_dir", ch), 64'(dir_seen[ch]), 64'(me.dir));
                    end
                end else if (done[ch]) begin
                    checkOutput($sformatf("ch%0d_stray_done", ch), 64'(done[ch]), 64'd0);
                end
                prev_en[ch] = enable_MANUAL[ch];
                prev_step[ch] = step[ch];
            end
        end
    end

    // Presents a one-cycle request; returns at the negedge of the first active cycle.
    task automatic request(input logic [1:0] s, input logic [1:0] sn, input logic [1:0] d,
                           input logic [31:0] n0, input logic [31:0] n1);
        @(negedge clk);
        start = s; start_N = sn; dir_in = d; PULSE_NUMBER = {n1, n0};
        @(negedge clk);
        start = '0; start_N = '0; dir_in = ~d; PULSE_NUMBER = {$urandom, $urandom};
    endtask

    task automatic waitIdle(input int limit);
        int c = 0;
        while (busy && c < limit) begin
            @(negedge clk);
            c++;
        end
        checkOutput("idle_timeout", 64'(busy), 64'd0);
        @(negedge clk);
    endtask

    // One move on one channel; k=0 runs to natural completion, else stop after k active cycles.
    task automatic applyStimulus(input int ch, input bit counted, input int n, input bit d,
                                 input int h, input int k);
        int heff;
        logic [1:0] m;
        heff = (h == 0) ? 1 : h;
        m = 2'(1 << ch);
        half_period = 16'(h);
        if (k == 0) pushExp(ch, (n == 0) ? 1 : 2 * n * heff, n, 1'b1, d);
        else pushExp(ch, k, (k - 1) / (2 * heff) + 1, 1'b0, d);
        request(counted ? 2'b00 : m, counted ? m : 2'b00, d ? m : 2'b00,
                (ch == 0) ? 32'(n) : $urandom, (ch == 1) ? 32'(n) : $urandom);
        if (k > 0) begin
            repeat (k - 1) @(negedge clk);
            stop[ch] = 1'b1;
            @(negedge clk);
            stop = '0;
        end
        waitIdle(300);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int h, heff, mode, ch, n, n1, k;
        bit d;

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("rst_enable", 64'(enable_MANUAL), 64'd0);
        checkOutput("rst_step", 64'(step), 64'd0);
        checkOutput("rst_dir", 64'(dir), 64'd0);
        checkOutput("rst_count", count_N, 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Counted move of 3 pulses, half period 2.
        applyStimulus(0, 1'b1, 3, 1'b0, 2, 0);

        // Continuous move, dir 1, stopped after 10 cycles; count and dir hold.
        applyStimulus(1, 1'b0, 0, 1'b1, 1, 10);
        repeat (3) @(negedge clk);
        checkOutput("ch1_count_held", 64'(count_N[63:32]), 64'd5);
        checkOutput("ch1_dir_held", 64'(dir[1]), 64'd1);
        checkOutput("ch1_step_idle", 64'(step[1]), 64'd0);

        // Zero-pulse counted move.
        applyStimulus(0, 1'b1, 0, 1'b1, 3, 0);

        // start and start_N together give a continuous move; later start_N is ignored.
        half_period = 16'd1;
        pushExp(0, 12, 6, 1'b0, 1'b0);
        request(2'b01, 2'b01, 2'b00, 32'd2, 32'd0);
        repeat (2) @(negedge clk);
        start_N[0] = 1'b1;
        @(negedge clk);
        start_N = '0;
        repeat (8) @(negedge clk);
        stop[0] = 1'b1;
        @(negedge clk);
        stop = '0;
        waitIdle(300);

        // Reset mid counted move while the other channel requests a start.
        half_period = 16'd1;
        request(2'b00, 2'b01, 2'b01, 32'd100, 32'd0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        start[1] = 1'b1;
        @(negedge clk);
        checkOutput("midrst_enable", 64'(enable_MANUAL), 64'd0);
        checkOutput("midrst_step", 64'(step), 64'd0);
        checkOutput("midrst_dir", 64'(dir), 64'd0);
        checkOutput("midrst_count", count_N, 64'd0);
        checkOutput("midrst_done", 64'(done), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        start = '0;
        q0.delete();
        q1.delete();
        @(negedge clk);
        checkOutput("postrst_busy", 64'(busy), 64'd0);

        // half_period 0 behaves as 1.
        applyStimulus(0, 1'b1, 2, 1'b0, 0, 0);

        // Randomized moves.
        for (int it = 0; it < 24; it++) begin
            h = $urandom_range(0, 3);
            heff = (h == 0) ? 1 : h;
            mode = $urandom_range(0, 3);
            ch = $urandom_range(0, 1);
            d = 1'($urandom_range(0, 1));
            case (mode)
                0: begin
                    n = $urandom_range(0, 5);
                    applyStimulus(ch, 1'b1, n, d, h, 0);
                end
                1: begin
                    n = $urandom_range(1, 5);
                    k = $urandom_range(1, 2 * n * heff - 1);
                    applyStimulus(ch, 1'b1, n, d, h, k);
                end
                2: begin
                    k = $urandom_range(1, 20);
                    applyStimulus(ch, 1'b0, 0, d, h, k);
                end
                default: begin
                    n = $urandom_range(0, 4);
                    n1 = $urandom_range(0, 4);
                    half_period = 16'(h);
                    pushExp(0, (n == 0) ? 1 : 2 * n * heff, n, 1'b1, d);
                    pushExp(1, (n1 == 0) ? 1 : 2 * n1 * heff, n1, 1'b1, ~d);
                    request(2'b00, 2'b11, {~d, d}, 32'(n), 32'(n1));
                    waitIdle(300);
                end
            endcase
        end

        repeat (2) @(negedge clk);
        checkOutput("queue0_drained", 64'(q0.size()), 64'd0);
        checkOutput("queue1_drained", 64'(q1.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tr_manual_mc.md
TR_MANUAL_MC -- requirements
Module: tr_manual_mc

Interface
REQ-001 Parameter WIDTH_MANUAL, default 16, sets half-width of pulse counters; counters and targets are 2*WIDTH_MANUAL bits.
REQ-002 Parameter CHANNELS, default 2, sets the number of independent tuner stepper channels.
REQ-003 Parameter DIV_WIDTH, default 16, sets the step half-period divider width.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  CHANNELS  per-channel request for continuous move, level-sampled.
REQ-007 start_N  input  CHANNELS  per-channel request for counted (N-pulse) move.
REQ-008 stop  input  CHANNELS  per-channel abort request.
REQ-009 dir_in  input  CHANNELS  per-channel requested direction, latched at move start.
REQ-010 PULSE_NUMBER  input  CHANNELS*2*WIDTH_MANUAL  per-channel pulse target, channel i in bits [i*2W +: 2W], latched at move start.
REQ-011 half_period  input  DIV_WIDTH  shared step high/low time in clk cycles; value 0 is treated as 1.
REQ-012 enable_MANUAL  output  CHANNELS  per-channel stepper-driver enable.
REQ-013 step  output  CHANNELS  per-channel step pulse.
REQ-014 dir  output  CHANNELS  per-channel latched direction.
REQ-015 count_N  output  CHANNELS*2*WIDTH_MANUAL  per-channel count of issued pulses in current/last move.
REQ-016 done  output  CHANNELS  one-cycle strobe when a counted move completes its target.
REQ-017 busy  output  1  OR of all enable_MANUAL bits.

Function
REQ-018 Each channel SHALL run an independent FSM with states IDLE, MOVE, MOVE_N; all outputs SHALL be registered.
REQ-019 In IDLE, start=1 SHALL enter MOVE next cycle; else start_N=1 SHALL enter MOVE_N; start wins when both are high; stop=1 in the same cycle SHALL suppress the start.
REQ-020 On entering MOVE/MOVE_N (cycle t+1 after request at t) the channel SHALL latch dir_in and PULSE_NUMBER, clear count_N to 0, and assert enable_MANUAL.
REQ-021 While active, step SHALL be high for half_period cycles then low for half_period cycles, repeating; the first rising edge SHALL occur in cycle t+1.
REQ-022 count_N SHALL increment by 1 in each cycle where step rises; it SHALL saturate at all-ones in MOVE (no wrap).
REQ-023 MOVE SHALL continue until stop=1; MOVE_N SHALL terminate when count_N equals the latched target and the last pulse's low phase has completed (exactly target pulses, never target+1).
REQ-024 MOVE_N with latched target 0 SHALL return to IDLE after one cycle with no step pulse and with done asserted.
REQ-025 On normal MOVE_N completion the return to IDLE, enable_MANUAL=0 and done=1 SHALL occur in the same cycle; done SHALL last exactly one cycle.
REQ-026 stop=1 in MOVE or MOVE_N SHALL return to IDLE next cycle with step=0 and enable_MANUAL=0; done SHALL NOT assert on abort.
REQ-027 In IDLE, step SHALL be 0, count_N SHALL hold its last value, dir SHALL hold; start/start_N while active SHALL be ignored.
REQ-028 half_period changes during a move SHALL take effect at the next phase boundary.
REQ-029 Channels SHALL not interact except through shared half_period and busy.

Reset
REQ-030 rst=1 SHALL force all FSMs to IDLE and enable_MANUAL, step, dir, count_N, done, busy to 0 on the next edge, overriding any move in progress and any concurrent start.

Verification
REQ-031 CH0 start_N, PULSE_NUMBER=3, half_period=2 -> enable high from t+1, exactly 3 step pulses (2 high/2 low), count_N=3, done one cycle at t+13, enable low same cycle.
REQ-032 CH1 start, dir_in=1, half_period=1, stop after 10 cycles -> step toggles every cycle, dir=1, enable/step low cycle after stop, no done, count_N=5 held.
REQ-033 start_N with PULSE_NUMBER=0 -> no step, done=1 at t+2, enable high only at t+1.
REQ-034 start and start_N same cycle -> MOVE; then start_N during MOVE -> ignored.
REQ-035 rst asserted mid MOVE_N on CH0 while CH1 starts -> all outputs 0 next cycle, both channels IDLE.
REQ-036 half_period=0 with start_N, PULSE_NUMBER=2 -> behaves as half_period=1, 2 pulses, done.
